branch_ctrl: RTL and testbench

Branch resolution controller for the LC-3b pipeline. It sits beside the branch condition comparator at the resolve stage and sequences each conditional branch through evaluation, CC-hazard stall, PC redirect and wrong-path flush. When the condition codes are still being produced by an older load in MEM, it stalls the front end until the memory response delivers forwarded NZP bits. It also keeps saturating performance counters for branches, taken branches and stall cycles.

---
 rtl/branch_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: evaluates LC-3b conditional branches, stalls on
// in-flight CC-writing loads, redirects the PC and flushes wrong-path work.
//
// state   | meaning
// IDLE    | no branch in flight; resolve immediately when CC is usable
// WAIT_CC | branch held with stall=1 until the load's memory response arrives
// FLUSH   | taken branch redirected; flush held while down-counter runs out
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       nzp,
  input  logic [2:0]       cc,
  input  logic             cc_pending,
  input  logic             mem_resp,
  input  logic [2:0]       mem_nzp,
  output logic             stall,
  output logic             pc_sel,
  output logic             flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_CC = 2'b01,
    FLUSH   = 2'b10
  } state_t;

  localparam logic [2:0]       FC_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       resolve;
  logic       use_mem;
  logic       taken_cc, taken_mem, taken;
  logic       cc_bypass;

  // nzp==111 is unconditional and nzp==000 is never taken, so neither needs CC
  assign cc_bypass = (nzp == 3'b111) || (nzp == 3'b000);
  assign taken_cc  = (nzp == 3'b111) || (|(nzp & cc));
  assign taken_mem = (nzp == 3'b111) || (|(nzp & mem_nzp));
  assign taken     = use_mem ? taken_mem : taken_cc;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    stall   = 1'b0;
    pc_sel  = 1'b0;
    flush   = 1'b0;
    resolve = 1'b0;
    use_mem = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (cc_bypass || !cc_pending) begin
            resolve = 1'b1;
          end else if (mem_resp) begin
            resolve = 1'b1;
            use_mem = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT_CC;
          end
        end
      end
      WAIT_CC: begin
        if (!br_valid) begin
          state_d = IDLE;
        end else if (mem_resp) begin
          resolve = 1'b1;
          use_mem = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        fcnt_d = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      state_d = IDLE;
      if (taken) begin
        pc_sel = 1'b1;
        flush  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FC_LOAD;
        end
      end
    end

    if (reset) begin
      stall  = 1'b0;
      pc_sel = 1'b0;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      branch_count <= '0;
      taken_count  <= '0;
      stall_count  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (resolve && branch_count != CNT_MAX) branch_count <= branch_count + CNT_W'(1);
      if (pc_sel && taken_count != CNT_MAX)   taken_count  <= taken_count + CNT_W'(1);
      if (stall && stall_count != CNT_MAX)    stall_count  <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: constant vector table, directed corner cases and
// randomized traffic checked against a cycle-level reference model.
module tb_branch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, br_valid, cc_pending, mem_resp;
  logic [2:0] nzp, cc, mem_nzp;

  logic        stall0, pc0, fl0;
  logic [1:0]  st0;
  logic [15:0] bc0, tc0, sc0;
  logic        stall1, pc1, fl1;
  logic [1:0]  st1;
  logic [1:0]  bc1, tc1, sc1;

  branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .br_valid(br_valid), .nzp(nzp), .cc(cc),
    .cc_pending(cc_pending), .mem_resp(mem_resp), .mem_nzp(mem_nzp),
    .stall(stall0), .pc_sel(pc0), .flush(fl0), .state(st0),
    .branch_count(bc0), .taken_count(tc0), .stall_count(sc0));

  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .br_valid(br_valid), .nzp(nzp), .cc(cc),
    .cc_pending(cc_pending), .mem_resp(mem_resp), .mem_nzp(mem_nzp),
    .stall(stall1), .pc_sel(pc1), .flush(fl1), .state(st1),
    .branch_count(bc1), .taken_count(tc1), .stall_count(sc1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-config pending-flush count, waiting flag, counters
  int  fcp[2]  = '{2, 3};
  int  cmax[2] = '{65535, 3};
  bit  known;
  bit  wt[2];
  int  fl_left[2], cb[2], ct[2], cs[2];
  bit  e_stall[2], e_pc[2], e_fl[2], e_res[2];
  int  e_st[2];

  function automatic void model_comb();
    bit use_mem;
    logic [2:0] src;
    for (int k = 0; k < 2; k++) begin
      e_stall[k] = 0; e_pc[k] = 0; e_fl[k] = 0; e_res[k] = 0; use_mem = 0;
      e_st[k] = (fl_left[k] > 0) ? 2 : (wt[k] ? 1 : 0);
      if (!reset) begin
        if (fl_left[k] > 0) e_fl[k] = 1;
        else if (br_valid) begin
          if (!wt[k] && (nzp == 3'b111 || nzp == 3'b000 || !cc_pending)) e_res[k] = 1;
          else if (mem_resp) begin e_res[k] = 1; use_mem = 1; end
          else e_stall[k] = 1;
        end
        if (e_res[k]) begin
          src = use_mem ? mem_nzp : cc;
          if (nzp == 3'b111 || (nzp & src) != 3'b000) begin e_pc[k] = 1; e_fl[k] = 1; end
        end
      end
    end
  endfunction

  function automatic void model_clock();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        wt[k] = 0; fl_left[k] = 0; cb[k] = 0; ct[k] = 0; cs[k] = 0;
      end else begin
        if (fl_left[k] > 0) fl_left[k]--;
        if (e_pc[k]) fl_left[k] = fcp[k] - 1;
        if (e_res[k])   cb[k] = (cb[k] + 1 > cmax[k]) ? cmax[k] : cb[k] + 1;
        if (e_pc[k])    ct[k] = (ct[k] + 1 > cmax[k]) ? cmax[k] : ct[k] + 1;
        if (e_stall[k]) cs[k] = (cs[k] + 1 > cmax[k]) ? cmax[k] : cs[k] + 1;
        wt[k] = e_stall[k];
      end
    end
    if (reset) known = 1;
  endfunction

  logic [2:0] s_comb0;
  logic [1:0] s_st0;

  task automatic step();
    @(negedge clk);
    model_comb();
    s_comb0 = {stall0, pc0, fl0};
    s_st0   = st0;
    chk("dut0 comb", {stall0, pc0, fl0}, {e_stall[0], e_pc[0], e_fl[0]});
    chk("dut1 comb", {stall1, pc1, fl1}, {e_stall[1], e_pc[1], e_fl[1]});
    if (known) begin
      chk("dut0 state", st0, e_st[0]);
      chk("dut1 state", st1, e_st[1]);
    end
    @(posedge clk);
    #1;
    model_clock();
    chk("dut0 counts", {bc0, tc0, sc0},
        (longint'(cb[0]) << 32) | (longint'(ct[0]) << 16) | longint'(cs[0]));
    chk("dut1 counts", {bc1, tc1, sc1}, (cb[1] << 4) | (ct[1] << 2) | cs[1]);
  endtask

  task automatic drive(input bit r, input bit b, input logic [2:0] n, input logic [2:0] c,
                       input bit p, input bit m, input logic [2:0] mn);
    reset = r; br_valid = b; nzp = n; cc = c; cc_pending = p; mem_resp = m; mem_nzp = mn;
    step();
  endtask

  typedef struct {
    bit br; logic [2:0] n; logic [2:0] c; bit p; bit m; logic [2:0] mn;
    logic [2:0] comb; int st; int bc; int tc; int sc;
  } vec_t;

  function automatic vec_t v(bit br, logic [2:0] n, logic [2:0] c, bit p, bit m,
                             logic [2:0] mn, logic [2:0] comb, int st, int bc, int tc, int sc);
    vec_t t;
    t.br = br; t.n = n; t.c = c; t.p = p; t.m = m; t.mn = mn;
    t.comb = comb; t.st = st; t.bc = bc; t.tc = tc; t.sc = sc;
    return t;
  endfunction

  vec_t tbl[24];

  initial begin
    // comb = {stall, pc_sel, flush}; counts are dut0 values after the edge
    tbl[0]  = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    tbl[1]  = v(1, 3'b010, 3'b010, 0, 0, 3'b000, 3'b011, 0, 1, 1, 0);
    tbl[2]  = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b001, 2, 1, 1, 0);
    tbl[3]  = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 1, 0);
    tbl[4]  = v(1, 3'b100, 3'b000, 1, 0, 3'b000, 3'b100, 0, 1, 1, 1);
    tbl[5]  = v(1, 3'b100, 3'b000, 1, 0, 3'b000, 3'b100, 1, 1, 1, 2);
    tbl[6]  = v(1, 3'b100, 3'b000, 1, 0, 3'b000, 3'b100, 1, 1, 1, 3);
    tbl[7]  = v(1, 3'b100, 3'b000, 1, 1, 3'b100, 3'b011, 1, 2, 2, 3);
    tbl[8]  = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b001, 2, 2, 2, 3);
    tbl[9]  = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 2, 2, 3);
    tbl[10] = v(1, 3'b100, 3'b100, 1, 0, 3'b000, 3'b100, 0, 2, 2, 4);
    tbl[11] = v(1, 3'b100, 3'b100, 1, 0, 3'b000, 3'b100, 1, 2, 2, 5);
    tbl[12] = v(1, 3'b100, 3'b100, 1, 0, 3'b000, 3'b100, 1, 2, 2, 6);
    tbl[13] = v(1, 3'b100, 3'b100, 1, 1, 3'b001, 3'b000, 1, 3, 2, 6);
    tbl[14] = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 3, 2, 6);
    tbl[15] = v(1, 3'b111, 3'b000, 1, 0, 3'b000, 3'b011, 0, 4, 3, 6);
    tbl[16] = v(1, 3'b010, 3'b010, 0, 0, 3'b000, 3'b001, 2, 4, 3, 6);
    tbl[17] = v(1, 3'b000, 3'b111, 1, 0, 3'b000, 3'b000, 0, 5, 3, 6);
    tbl[18] = v(1, 3'b001, 3'b001, 1, 0, 3'b000, 3'b100, 0, 5, 3, 7);
    tbl[19] = v(0, 3'b001, 3'b001, 1, 0, 3'b000, 3'b000, 1, 5, 3, 7);
    tbl[20] = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 5, 3, 7);
    tbl[21] = v(1, 3'b010, 3'b000, 1, 1, 3'b010, 3'b011, 0, 6, 4, 7);
    tbl[22] = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b001, 2, 6, 4, 7);
    tbl[23] = v(0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 6, 4, 7);

    known = 0;
    reset = 1; br_valid = 0; nzp = 0; cc = 0; cc_pending = 0; mem_resp = 0; mem_nzp = 0;
    @(posedge clk);
    #1;

    // Reset held for 3 cycles with random inputs
    for (int i = 0; i < 3; i++)
      drive(1, 1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    chk("reset state", st0, 0);
    chk("reset counters", {bc0, tc0, sc0}, 0);

    for (int i = 0; i < 24; i++) begin
      drive(0, tbl[i].br, tbl[i].n, tbl[i].c, tbl[i].p, tbl[i].m, tbl[i].mn);
      chk($sformatf("vec%0d comb", i), s_comb0, tbl[i].comb);
      chk($sformatf("vec%0d state", i), s_st0, tbl[i].st);
      chk($sformatf("vec%0d counts", i), {bc0, tc0, sc0},
          (longint'(tbl[i].bc) << 32) | (longint'(tbl[i].tc) << 16) | longint'(tbl[i].sc));
    end

    // Reset while waiting on CC
    drive(0, 1, 3'b100, 3'b000, 1, 0, 3'b000);
    drive(0, 1, 3'b100, 3'b000, 1, 0, 3'b000);
    chk("enter wait_cc", s_st0, 1);
    drive(1, 1, 3'b100, 3'b000, 1, 0, 3'b000);
    chk("reset in wait comb", s_comb0, 0);
    drive(0, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    chk("after reset stall", s_comb0, 0);
    chk("after reset state", s_st0, 0);
    chk("after reset branch_count", bc0, 0);

    // Five taken branches: the 2-bit counters saturate at 3
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 3'b111, 3'b000, 0, 0, 3'b000);
      repeat (3) drive(0, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    end
    chk("sat taken_count cnt2", tc1, 3);
    chk("sat branch_count cnt2", bc1, 3);
    chk("taken_count cnt16", tc0, 5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 64) == 0, ($urandom % 4) != 0, 3'($urandom), 3'($urandom),
            1'($urandom), ($urandom % 4) == 0, 3'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
